// File: rtl/serial_twos_complement_if.sv
// Operand/result handshake bundle for the bit-serial two's complement negator.
// valid/ready: a transfer happens on a rising edge where both valid and ready are high.
interface serial_twos_complement_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, ovf
  );
endinterface

// File: rtl/serial_twos_complement.sv
// Bit-serial LSB-first negator: out = (~in + 1) mod 2^WIDTH over WIDTH shift cycles,
// using a shift register and a one-bit "a one has been seen" flag instead of an adder.
module serial_twos_complement #(
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  serial_twos_complement_if.slave     bus,
  output logic                        busy,
  output logic [1:0]                  state_dbg
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic             seen_one;
  logic             ovf_pending;
  logic             bit_in;
  logic             bit_out;

  // Bits below and including the first one pass through; every later bit is inverted.
  assign bit_in  = shreg[0];
  assign bit_out = seen_one ? ~bit_in : bit_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)         state_next = SHIFT;
      SHIFT:   if (count == LAST_CNT)    state_next = DONE;
      DONE:    if (bus.out_ready)        state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      count       <= '0;
      seen_one    <= 1'b0;
      ovf_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            shreg       <= bus.in_data;
            count       <= '0;
            seen_one    <= 1'b0;
            ovf_pending <= (bus.in_data == MOST_NEG);
          end
        end
        SHIFT: begin
          shreg    <= {bit_out, shreg[WIDTH-1:1]};
          seen_one <= seen_one | bit_in;
          if (count != LAST_CNT) begin
            count <= count + 1'b1;
          end
        end
        default: begin
          // DONE holds the result untouched until the consumer takes it.
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = shreg;
  assign bus.ovf       = (state == DONE) & ovf_pending;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_serial_twos_complement.sv
// Directed-plus-random bench for serial_twos_complement (WIDTH=4) against an arithmetic negation model.
module tb_serial_twos_complement;

  localparam int WIDTH = 4;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [1:0] state_dbg;
  int         checks;
  int         errors;
  logic [WIDTH-1:0] exp_q[$];
  logic             ovf_q[$];

  serial_twos_complement_if #(.WIDTH(WIDTH)) bus ();

  serial_twos_complement #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: modular negation by plain arithmetic
  function automatic logic [WIDTH-1:0] model_neg(input int x);
    int r;
    r = ((1 << WIDTH) - x) % (1 << WIDTH);
    return r[WIDTH-1:0];
  endfunction

  function automatic logic model_ovf(input int x);
    return (x == (1 << (WIDTH - 1)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one operand through the block, with an optional output stall
  task automatic do_op(input logic [WIDTH-1:0] x, input int stall, input string tag);
    int  edges;
    bit  got;
    bit  rdy;
    rdy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin rdy = 1; break; end
    end
    chk({tag, "_ready_timeout"}, 32'(rdy), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_data   = x;
    bus.out_ready = (stall == 0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    exp_q.push_back(model_neg(int'(x)));
    ovf_q.push_back(model_ovf(int'(x)));
    edges = 1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin got = 1; break; end
      @(posedge clk);
      edges++;
    end
    chk({tag, "_valid_timeout"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(edges), 32'(WIDTH + 1));
    begin
      logic [WIDTH-1:0] ed;
      logic             eo;
      ed = exp_q.pop_front();
      eo = ovf_q.pop_front();
      chk({tag, "_data"}, 32'(bus.out_data), 32'(ed));
      chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
      chk({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_busy_done"}, 32'(busy), 32'd1);
      for (int s = 0; s < stall; s++) begin
        bus.in_valid = 1'b1;
        bus.in_data  = WIDTH'($urandom);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_stall_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_stall_data"}, 32'(bus.out_data), 32'(ed));
        chk({tag, "_stall_ovf"}, 32'(bus.ovf), 32'(eo));
        chk({tag, "_stall_in_ready"}, 32'(bus.in_ready), 32'd0);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_release_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_release_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_release_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int perm[16];
    int idx, cyc, ndone, last_acc, seen_bad;
    bit acc;
    checks = 0;
    errors = 0;

    // 1. reset with random inputs; in_valid high under reset must not be accepted
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = WIDTH'($urandom);
    bus.out_ready = 1'($urandom_range(0, 1));
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_busy", 32'(busy), 32'd0);
    chk("rst_hold_out_data", 32'(bus.out_data), 32'd0);
    bus.in_valid = 1'b0;
    rst = 1'b0;

    // 2. basic values
    do_op(4'b0001, 0, "b0001");
    do_op(4'b1111, 0, "b1111");
    do_op(4'b0110, 0, "b0110");
    do_op(4'b0000, 0, "b0000");
    // 3. overflow and the operand after it
    do_op(4'b1000, 0, "ovf1000");
    do_op(4'b0011, 0, "after_ovf");
    // 4. backpressure
    do_op(4'b0101, 7, "stall");
    // random operands with random stalls
    for (int k = 0; k < 6; k++) begin
      do_op(WIDTH'($urandom), $urandom_range(0, 3), "rand");
    end

    // 5. reset mid-operation
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b0111;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid || busy) seen_bad++;
    end
    chk("midrst_no_result", 32'(seen_bad), 32'd0);
    do_op(4'b0010, 0, "after_midrst");

    // 6. exhaustive back-to-back with in_valid held high, random order
    for (int i = 0; i < 16; i++) perm[i] = i;
    for (int i = 15; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    @(negedge clk);
    idx = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = WIDTH'(perm[0]);
    bus.out_ready = 1'b1;
    cyc = 0;
    ndone = 0;
    last_acc = -1;
    while (ndone < 16 && cyc < 300) begin
      if (cyc > 0) @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        logic [WIDTH-1:0] ed;
        logic             eo;
        if (exp_q.size() == 0) begin
          chk("b2b_unexpected_result", 32'(exp_q.size()), 32'd1);
        end else begin
          ed = exp_q.pop_front();
          eo = ovf_q.pop_front();
          chk("b2b_data", 32'(bus.out_data), 32'(ed));
          chk("b2b_ovf", 32'(bus.ovf), 32'(eo));
        end
        ndone++;
      end
      if (acc) begin
        exp_q.push_back(model_neg(int'(bus.in_data)));
        ovf_q.push_back(model_ovf(int'(bus.in_data)));
        if (last_acc >= 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'(WIDTH + 2));
        last_acc = cyc;
        idx++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (idx < 16) bus.in_data = WIDTH'(perm[idx]);
        else          bus.in_valid = 1'b0;
      end
      cyc++;
    end
    chk("b2b_all_done", 32'(ndone), 32'd16);
    chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_twos_complement.md
Name: serial_twos_complement

Overview:
Bit-serial, LSB-first two's complement negator with valid/ready handshakes on input and output. It computes the same function as the combinational two's complement inverter, out = (~in + 1) mod 2^WIDTH, in WIDTH clock cycles. It needs only a shift register and a one-bit carry state instead of a WIDTH-bit adder. The block sits in the datapath as an area-reduced drop-in stage, feeding a downstream consumer through out_valid/out_ready.

Parameters:
WIDTH, 4, operand and result width in bits; legal values >= 2.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream presents an operand on in_data
in_ready  output  1  block can accept an operand this cycle
in_data  input  WIDTH  operand to negate
out_valid  output  1  out_data and ovf hold a completed result
out_ready  input  1  downstream consumes the result this cycle
out_data  output  WIDTH  two's complement of the accepted operand
ovf  output  1  operand was the most-negative value (1 followed by WIDTH-1 zeros); result equals input
busy  output  1  high while in SHIFT or DONE

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, shift register=0, count=0, seen_one=0.
  - out_data=0, out_valid=0, ovf=0, busy=0, in_ready=1.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - On a clock edge with in_valid=1: load shift register with in_data, count=0, seen_one=0, capture ovf_pending = (in_data == {1'b1, {WIDTH-1{1'b0}}}), go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1. in_valid is ignored.
  - Each cycle takes b = shreg[0] and forms r = seen_one ? ~b : b.
  - Then: shreg <= {r, shreg[WIDTH-1:1]}, seen_one <= seen_one | b, count <= count+1.
  - When count == WIDTH-1 (the last bit is processed on that edge), go to DONE.
- DONE:
  - out_valid=1, out_data=shreg, ovf=ovf_pending, busy=1, in_ready=0.
  - out_data and ovf stay stable while out_valid=1 and out_ready=0 (no drop, no change).
  - On an edge with out_ready=1, go to IDLE. out_valid falls and in_ready rises after that edge.
  - No same-cycle accept of a new operand in DONE.
- Latency: out_valid rises exactly WIDTH+1 rising edges after the accepting edge (1 load edge + WIDTH shift edges).
- Throughput: at most one operand per WIDTH+2 cycles when out_ready is held high.
- Arithmetic: result is modulo 2^WIDTH.
  - Input 0 gives 0, with ovf=0.
  - Most-negative input gives itself, with ovf=1.
  - No other input sets ovf.
- out_data is registered; its value outside DONE is don't-care, except 0 after reset.
- Reset mid-operation (rst asserted in SHIFT or DONE): the operand is discarded and all reset values apply immediately. After rst deasserts, no out_valid pulse appears for the discarded operand.
- in_valid held high across the return to IDLE: the new operand is accepted on the first edge in IDLE.
- Count width is clog2(WIDTH) bits, minimum 1. The count does not wrap within an operation.

Test Plan:
WIDTH=4 for all scenarios.
1. Reset check: assert rst at time 0 with random inputs -> out_valid=0, in_ready=1, out_data=4'b0000, ovf=0, busy=0. Drive in_valid=1 while rst=1 -> nothing accepted.
2. Basic values, out_ready=1: in_data=4'b0001 -> 4'b1111; 4'b1111 -> 4'b0001; 4'b0110 -> 4'b1010; 4'b0000 -> 4'b0000. Each has ovf=0, and out_valid rises exactly 5 edges after acceptance.
3. Overflow: in_data=4'b1000 -> out_data=4'b1000, ovf=1. Next operand 4'b0011 -> 4'b1101, ovf=0.
4. Backpressure: accept 4'b0101 with out_ready=0 for 7 cycles after out_valid rises -> out_data=4'b1011 held stable and in_ready=0 throughout. in_data changes during the stall are ignored. Raise out_ready -> IDLE on the next edge.
5. Reset mid-operation: accept 4'b0111, assert rst after 2 shift edges, release it -> state IDLE and out_valid never asserts for 4'b0111. The next operand 4'b0010 -> 4'b1110.
6. Exhaustive back-to-back: in_valid held high, out_ready=1, all 16 inputs -> every out_data equals (~in+1)&4'hF. Accept spacing is 6 cycles, and ovf=1 only for 4'b1000.
